// File: rtl/data_mem_bridge.sv
// Bridges the single-cycle core's data-memory port to a multi-cycle req/ack bus.
// Stalls the core while a transfer is outstanding and flags bad or timed-out accesses.
module data_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   rdata_q;
    logic          access;
    logic          legal;
    logic          launch;
    logic          reject;

    assign access = mem_read | mem_write;
    assign legal  = (addr[1:0] == 2'b00) && !(mem_read && mem_write);
    assign launch = (state == IDLE) && access && legal;
    assign reject = (state == IDLE) && access && !legal;

    // The launch cycle must stall before the request register is set, hence combinational.
    assign stall     = launch || (state == BUSY);
    assign read_data = rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rdata_q   <= '0;
            fault     <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wdata <= write_data;
                        bus_we    <= mem_write;
                        bus_req   <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= BUSY;
                    end else if (reject) begin
                        fault   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            rdata_q <= bus_rdata;
                        end
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        // Abandon the transfer; a load returns zero rather than stale data.
                        fault   <= 1'b1;
                        rdata_q <= '0;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (wait_cnt != {CW{1'b1}}) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Self-checking bench for data_mem_bridge: transaction-level model builds a per-cycle
// expectation queue which one negedge process compares against the DUT.
module tb_data_mem_bridge;

    localparam int T = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata = '0;
    logic        bus_ack = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    data_mem_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .write_data(write_data), .read_data(read_data), .stall(stall),
        .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        bus_req;
        logic        bus_we;
        logic        fault;
        logic [31:0] bus_addr;
        logic [31:0] bus_wdata;
        logic [31:0] read_data;
    } exp_t;

    exp_t expq[$];

    // Architectural state of the bridge as seen by the core and the bus.
    logic        m_fault = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;

    int req_run = 0;
    int last_req_run = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("stall", {31'b0, stall}, {31'b0, e.stall});
            checkOutput("bus_req", {31'b0, bus_req}, {31'b0, e.bus_req});
            checkOutput("bus_we", {31'b0, bus_we}, {31'b0, e.bus_we});
            checkOutput("fault", {31'b0, fault}, {31'b0, e.fault});
            checkOutput("bus_addr", bus_addr, e.bus_addr);
            checkOutput("bus_wdata", bus_wdata, e.bus_wdata);
            checkOutput("read_data", read_data, e.read_data);
        end
        if (bus_req === 1'b1) begin
            req_run++;
        end else if (req_run != 0) begin
            last_req_run = req_run;
            req_run = 0;
        end
    end

    task automatic pushExp(input logic s, input logic r);
        exp_t e;
        e.stall = s;
        e.bus_req = r;
        e.bus_we = m_we;
        e.fault = m_fault;
        e.bus_addr = m_addr;
        e.bus_wdata = m_wdata;
        e.read_data = m_rdata;
        expq.push_back(e);
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic ack,
                                 input logic [31:0] rdat, input logic rst);
        @(posedge clk);
        #1;
        mem_read = rd;
        mem_write = wr;
        addr = a;
        write_data = wd;
        bus_ack = ack;
        bus_rdata = rdat;
        reset = rst;
    endtask

    task automatic junkCycle(input logic ack, input logic [31:0] rdat);
        applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, ack, rdat, 1'b0);
    endtask

    task automatic modelReset();
        m_fault = 1'b0;
        m_rdata = '0;
        m_we = 1'b0;
        m_addr = '0;
        m_wdata = '0;
    endtask

    task automatic idleCycle(input logic ack);
        applyStimulus(1'b0, 1'b0, $urandom, $urandom, ack, $urandom, 1'b0);
        pushExp(1'b0, 1'b0);
    endtask

    // delay = no-ack BUSY cycles before ack (>= T means never acked);
    // reset_at = BUSY cycle index in which reset is asserted, or -1.
    task automatic doTransfer(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input int delay,
                              input logic [31:0] rdat, input int reset_at);
        int n_busy;
        applyStimulus(rd, wr, a, wd, 1'($urandom), $urandom, 1'b0);
        if (!(rd || wr)) begin
            pushExp(1'b0, 1'b0);
            return;
        end
        if (a[1:0] != 2'b00 || (rd && wr)) begin
            pushExp(1'b0, 1'b0);
            m_fault = 1'b1;
            m_rdata = '0;
            return;
        end
        pushExp(1'b1, 1'b0);
        m_addr = a;
        m_wdata = wd;
        m_we = wr;
        n_busy = (delay < T) ? delay + 1 : T;
        for (int i = 0; i < n_busy; i++) begin
            if (i == reset_at) begin
                applyStimulus(1'($urandom), 1'($urandom), $urandom, $urandom, 1'b0, $urandom, 1'b1);
                pushExp(1'b1, 1'b1);
                modelReset();
                return;
            end
            junkCycle(i == delay, (i == delay) ? rdat : $urandom);
            pushExp(1'b1, 1'b1);
        end
        if (delay < T) begin
            if (!wr) m_rdata = rdat;
        end else begin
            m_fault = 1'b1;
            m_rdata = '0;
        end
        junkCycle(1'($urandom), $urandom);
        pushExp(1'b0, 1'b0);
    endtask

    initial begin
        int delay;
        int kind;
        logic [31:0] a;

        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        idleCycle(1'b1);
        checkOutput("reset_read_data", read_data, 32'h0);
        checkOutput("reset_bus_addr", bus_addr, 32'h0);

        // Load acked in the first BUSY cycle.
        doTransfer(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hCAFEF00D, -1);
        checkOutput("load1_read_data", read_data, 32'hCAFEF00D);
        checkOutput("load1_bus_addr", bus_addr, 32'h100);
        checkOutput("load1_bus_we", {31'b0, bus_we}, 32'h0);

        // Store with three wait cycles.
        doTransfer(1'b0, 1'b1, 32'h20, 32'h12345678, 3, 32'h0, -1);
        checkOutput("store_bus_wdata", bus_wdata, 32'h12345678);
        checkOutput("store_bus_we", {31'b0, bus_we}, 32'h1);
        checkOutput("store_read_data", read_data, 32'hCAFEF00D);
        idleCycle(1'b0);
        checkOutput("store_req_len", last_req_run, 4);

        // Timeout, then a successful load with fault still set.
        doTransfer(1'b1, 1'b0, 32'h40, 32'h0, 100, 32'h0, -1);
        checkOutput("timeout_fault", {31'b0, fault}, 32'h1);
        checkOutput("timeout_read_data", read_data, 32'h0);
        idleCycle(1'b0);
        checkOutput("timeout_req_len", last_req_run, T);
        doTransfer(1'b1, 1'b0, 32'h44, 32'h0, 1, 32'h0BADBEEF, -1);
        checkOutput("after_to_read_data", read_data, 32'h0BADBEEF);
        checkOutput("after_to_fault", {31'b0, fault}, 32'h1);

        // Reset, then misaligned and conflicting accesses.
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
        pushExp(1'b0, 1'b0);
        modelReset();
        doTransfer(1'b1, 1'b0, 32'h102, 32'h0, 0, 32'h55, -1);
        idleCycle(1'b0);
        checkOutput("misaligned_fault", {31'b0, fault}, 32'h1);
        checkOutput("misaligned_read_data", read_data, 32'h0);
        doTransfer(1'b1, 1'b1, 32'h200, 32'h0, 0, 32'h55, -1);
        idleCycle(1'b0);
        checkOutput("conflict_bus_req", {31'b0, bus_req}, 32'h0);

        // Reset in the second BUSY cycle, then a late ack.
        doTransfer(1'b1, 1'b0, 32'h300, 32'h0, 5, 32'h77, 1);
        idleCycle(1'b1);
        checkOutput("rst_mid_fault", {31'b0, fault}, 32'h0);
        checkOutput("rst_mid_read_data", read_data, 32'h0);
        checkOutput("rst_mid_bus_req", {31'b0, bus_req}, 32'h0);

        // Back-to-back loads.
        doTransfer(1'b1, 1'b0, 32'h400, 32'h0, 0, 32'h11112222, -1);
        checkOutput("b2b_first", read_data, 32'h11112222);
        doTransfer(1'b1, 1'b0, 32'h404, 32'h0, 0, 32'h33334444, -1);
        checkOutput("b2b_second", read_data, 32'h33334444);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            delay = ($urandom_range(0, 7) == 0) ? $urandom_range(T - 2, T + 3) : $urandom_range(0, 4);
            a = {$urandom_range(0, 255), 2'b00};
            case (kind)
                0: doTransfer(1'b0, 1'b0, $urandom, $urandom, 0, 32'h0, -1);
                1: doTransfer(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), 32'h0, 0, 32'h0, -1);
                2: doTransfer(1'b1, 1'b1, a, $urandom, 0, 32'h0, -1);
                3: begin
                    doTransfer(1'b1, 1'b0, a, 32'h0, delay, $urandom, $urandom_range(0, 3));
                    idleCycle(1'b1);
                end
                4, 5, 6: doTransfer(1'b1, 1'b0, a, 32'h0, delay, $urandom, -1);
                default: doTransfer(1'b0, 1'b1, a, $urandom, delay, $urandom, -1);
            endcase
        end

        idleCycle(1'b0);
        idleCycle(1'b0);
        @(posedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
